registers_dump: RTL and testbench

Debug-path consumer of the register bank's flat debug bus. On a start request it snapshots every register in one cycle. It then streams the snapshot out one byte at a time over a valid/ready handshake to the debug UART transmitter. It sits between the ID-stage register bank and the debug unit's TX path, so a full register dump reaches the host PC.

---
 rtl/registers_dump.sv | 97 +++++++++
 tb/tb_registers_dump.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/registers_dump.sv
// Purpose: snapshots the flat register debug bus on request and streams it out byte by byte.
// Latency: byte 0 is offered the cycle after start. One byte per cycle at full rate. o_done pulses the cycle after the last byte is accepted.
// Backpressure: o_tx_data and o_tx_valid hold while i_tx_ready is low. Each stalled cycle adds one cycle.
module registers_dump #(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int REGISTERS_SIZE      = 32,
  parameter int BYTE_SIZE           = 8
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic                                          i_start,
  input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
  input  logic                                          i_tx_ready,
  output logic [BYTE_SIZE-1:0]                          o_tx_data,
  output logic                                          o_tx_valid,
  output logic                                          o_busy,
  output logic                                          o_done
);

  localparam int BYTES_PER_REG = REGISTERS_SIZE / BYTE_SIZE;
  localparam int TOTAL         = REGISTERS_BANK_SIZE * BYTES_PER_REG;
  localparam int CNT_W         = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                          state_q;
  state_t                          state_d;
  logic [CNT_W-1:0]                cnt_q;
  logic [TOTAL-1:0][BYTE_SIZE-1:0] snap_q;
  logic [TOTAL-1:0][BYTE_SIZE-1:0] snap_in;
  logic                            xfer;
  logic                            last_byte;

  // Reorder the register image into transmit order at capture time.
  // Element k of the snapshot is then simply the k-th byte to send:
  // registers ascending, most-significant byte of each register first.
  for (genvar k = 0; k < TOTAL; k++) begin : g_order
    localparam int REG_IDX  = k / BYTES_PER_REG;
    localparam int BYTE_IDX = BYTES_PER_REG - 1 - (k % BYTES_PER_REG);
    assign snap_in[k] = i_bus_debug[REG_IDX*REGISTERS_SIZE + BYTE_IDX*BYTE_SIZE +: BYTE_SIZE];
  end

  assign xfer      = (state_q == SEND) && i_tx_ready;
  assign last_byte = (cnt_q == LAST);

  // Next-state selection and output decode from registered state only.
  always_comb begin
    state_d    = state_q;
    o_tx_data  = '0;
    o_tx_valid = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) state_d = SEND;
      end
      SEND: begin
        o_tx_valid = 1'b1;
        o_busy     = 1'b1;
        o_tx_data  = snap_q[cnt_q];
        if (xfer && last_byte) state_d = DONE;
      end
      DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Snapshot capture on start and byte counter advance on each accepted byte.
  // The counter stops at the last index rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else if ((state_q == IDLE) && i_start) begin
      cnt_q  <= '0;
      snap_q <= snap_in;
    end else if (xfer && !last_byte) begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_registers_dump.sv
// Bench for registers_dump: default 32x32 instance plus a 4x16 instance.
// Expected bytes are queued when a dump is started; monitors pop them on each handshake.
// Timing of o_done is checked against the start edge plus accepted and stalled cycles.
module tb_registers_dump;

  localparam int NB = 32, RS = 32, BS = 8, TOTAL = 128;
  localparam int NB_B = 4, RS_B = 16, TOTAL_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-size instance
  logic               a_rst, a_start, a_ready;
  logic [NB*RS-1:0]   a_bus;
  logic [BS-1:0]      a_data;
  logic               a_valid, a_busy, a_done;

  // small instance
  logic               b_rst, b_start, b_ready;
  logic [NB_B*RS_B-1:0] b_bus;
  logic [BS-1:0]      b_data;
  logic               b_valid, b_busy, b_done;

  registers_dump #(.REGISTERS_BANK_SIZE(NB), .REGISTERS_SIZE(RS), .BYTE_SIZE(BS)) dut_a (
    .i_clk(clk), .i_reset(a_rst), .i_start(a_start), .i_bus_debug(a_bus),
    .i_tx_ready(a_ready), .o_tx_data(a_data), .o_tx_valid(a_valid),
    .o_busy(a_busy), .o_done(a_done)
  );

  registers_dump #(.REGISTERS_BANK_SIZE(NB_B), .REGISTERS_SIZE(RS_B), .BYTE_SIZE(BS)) dut_b (
    .i_clk(clk), .i_reset(b_rst), .i_start(b_start), .i_bus_debug(b_bus),
    .i_tx_ready(b_ready), .o_tx_data(b_data), .o_tx_valid(b_valid),
    .o_busy(b_busy), .o_done(b_done)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- scoreboard / monitor, instance A ----------------
  logic [7:0] q_a[$];
  int         acc_a = 0, stall_a = 0, done_cnt_a = 0, done_edge_a = -1;
  logic       prev_stall_a = 1'b0, prev_rst_a = 1'b1;
  logic [7:0] prev_dat_a = '0;

  always @(negedge clk) begin
    if (prev_stall_a && !prev_rst_a) begin
      check("a_hold_valid", a_valid, 1);
      check("a_hold_data", a_data, prev_dat_a);
    end
    if (a_valid === 1'b1 && a_ready === 1'b1) begin
      check("a_byte_expected", q_a.size() > 0, 1);
      if (q_a.size() > 0) check("a_byte", a_data, q_a.pop_front());
      acc_a++;
    end
    if (a_valid === 1'b1 && a_ready === 1'b0) stall_a++;
    if (a_done === 1'b1) begin
      done_cnt_a++;
      done_edge_a = cyc;
      check("a_done_queue_drained", q_a.size(), 0);
    end
    prev_stall_a = (a_valid === 1'b1) && (a_ready === 1'b0);
    prev_dat_a   = a_data;
    prev_rst_a   = a_rst;
  end

  // ---------------- scoreboard / monitor, instance B ----------------
  logic [7:0] q_b[$];
  int         acc_b = 0, done_cnt_b = 0, done_edge_b = -1;

  always @(negedge clk) begin
    if (b_valid === 1'b1 && b_ready === 1'b1) begin
      check("b_byte_expected", q_b.size() > 0, 1);
      if (q_b.size() > 0) check("b_byte", b_data, q_b.pop_front());
      acc_b++;
    end
    if (b_done === 1'b1) begin
      done_cnt_b++;
      done_edge_b = cyc;
      check("b_done_queue_drained", q_b.size(), 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register j = base + j*step; drive the bus and queue the bytes MSB first.
  task automatic load_a(input logic [31:0] base, input logic [31:0] step);
    logic [31:0] v;
    for (int j = 0; j < NB; j++) begin
      v = base + step * 32'(j);
      a_bus[j*RS +: RS] = v;
      q_a.push_back(v[31:24]);
      q_a.push_back(v[23:16]);
      q_a.push_back(v[15:8]);
      q_a.push_back(v[7:0]);
    end
  endtask

  // Start a dump on instance A; returns the edge number at which start is sampled.
  task automatic kick_a(output int n);
    a_start = 1'b1;
    n = cyc + 1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input int prev, input string name);
    int t = 0;
    while (done_cnt_a == prev && t < 400) begin
      tick();
      t++;
    end
    check(name, done_cnt_a, prev + 1);
  endtask

  task automatic wait_bytes_a(input int n, input string name);
    int t = 0;
    while (acc_a < n && t < 400) begin
      tick();
      t++;
    end
    check(name, acc_a >= n, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, d0;
    logic [7:0] lfsr;

    // ---- reset with arbitrary inputs ----
    a_rst = 1'b1; a_start = 1'b1; a_ready = 1'b1;
    for (int j = 0; j < NB; j++) a_bus[j*RS +: RS] = $urandom;
    b_rst = 1'b1; b_start = 1'b1; b_ready = 1'b1; b_bus = 64'hDEAD_BEEF_0123_4567;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_a_data", a_data, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_b_busy", b_busy, 0);
    @(posedge clk); #1;
    a_rst = 1'b0; a_start = 1'b0;
    b_rst = 1'b0; b_start = 1'b0;
    tick();

    // ---- full dump, ready always high ----
    acc_a = 0; d0 = done_cnt_a;
    load_a(32'hA0B0_C000, 32'h1);
    kick_a(n);
    wait_done_a(d0, "full_done_seen");
    check("full_done_edge", done_edge_a, n + TOTAL);
    check("full_byte_count", acc_a, TOTAL);
    @(negedge clk);
    check("full_idle_busy", a_busy, 0);
    check("full_idle_done", a_done, 0);
    tick();

    // ---- backpressure ----
    acc_a = 0; stall_a = 0; d0 = done_cnt_a; lfsr = 8'hA5;
    load_a(32'h1357_9BDF, 32'h0102_0304);
    a_ready = 1'b1;
    kick_a(n);
    for (int t = 0; t < 2000 && done_cnt_a == d0; t++) begin
      a_ready = lfsr[0];
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      tick();
    end
    check("bp_done_seen", done_cnt_a, d0 + 1);
    check("bp_byte_count", acc_a, TOTAL);
    check("bp_done_edge", done_edge_a, n + TOTAL + stall_a);
    check("bp_had_stalls", stall_a > 0, 1);
    a_ready = 1'b1;
    tick();

    // ---- snapshot held, start ignored mid-dump ----
    acc_a = 0; d0 = done_cnt_a;
    load_a(32'h0F1E_2D3C, 32'h1111_0101);
    kick_a(n);
    wait_bytes_a(6, "snap_reach_byte5");
    a_bus = '1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_done_a(d0, "snap_done_seen");
    check("snap_done_edge", done_edge_a, n + TOTAL);
    check("snap_byte_count", acc_a, TOTAL);
    @(negedge clk);
    check("snap_no_restart", a_busy, 0);
    tick();

    // ---- reset mid-dump ----
    acc_a = 0; d0 = done_cnt_a;
    load_a(32'h5500_AA00, 32'h0001_0001);
    kick_a(n);
    wait_bytes_a(41, "mid_reach_byte40");
    a_rst = 1'b1; a_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", a_valid, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_data", a_data, 0);
    q_a.delete();
    @(posedge clk); #1;
    a_rst = 1'b0; a_ready = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    check("mid_no_done", done_cnt_a, d0);
    acc_a = 0;
    load_a(32'h8899_AABB, 32'h0000_0100);
    kick_a(n);
    wait_done_a(d0, "mid_redump_done");
    check("mid_redump_edge", done_edge_a, n + TOTAL);
    check("mid_redump_count", acc_a, TOTAL);

    // ---- small configuration ----
    b_bus = {16'h7788, 16'h5566, 16'h3344, 16'h1122};
    q_b.push_back(8'h11); q_b.push_back(8'h22); q_b.push_back(8'h33); q_b.push_back(8'h44);
    q_b.push_back(8'h55); q_b.push_back(8'h66); q_b.push_back(8'h77); q_b.push_back(8'h88);
    acc_b = 0;
    b_start = 1'b1;
    n = cyc + 1;
    tick();
    b_start = 1'b0;
    for (int t = 0; t < 50 && done_cnt_b == 0; t++) tick();
    check("b_done_seen", done_cnt_b, 1);
    check("b_done_edge", done_edge_b, n + TOTAL_B);
    check("b_byte_count", acc_b, TOTAL_B);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
